// File: rtl/tt_um_seven_segment_sniffer.sv
// Seven-segment sniffer: synchronizes a segment drive pattern, debounces it,
// decodes stable patterns to hex digits and checks that they form a counting sequence.
module tt_um_seven_segment_sniffer #(
  parameter int         STABLE_CYCLES = 16,
  parameter logic [3:0] WRAP          = 4'd9
) (
  input  logic [7:0] ui_in,
  output logic [7:0] uo_out,
  input  logic [7:0] uio_in,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe,
  input  logic       ena,
  input  logic       clk,
  input  logic       rst_n
);

  localparam logic [7:0] CNT_MAX       = 8'(STABLE_CYCLES - 1);
  localparam logic [0:0] ST_WAIT_FIRST = 1'b0;
  localparam logic [0:0] ST_TRACK      = 1'b1;

  logic [7:0] sync1, s;
  logic [6:0] cand, last_acc;
  logic [7:0] cnt;
  logic [3:0] digit;
  logic       valid, bad_pat, seq_err, strobe;
  logic [7:0] count;
  logic [0:0] state;

  logic [6:0] p;
  logic       c;
  logic       accept_rdy;
  logic       hex_ok;
  logic [3:0] hex_val;
  logic [3:0] exp_next;

  assign p          = s[6:0];
  assign c          = s[7];
  assign accept_rdy = (cnt == CNT_MAX) && (cand != last_acc);
  assign exp_next   = (digit == WRAP) ? 4'd0 : digit + 4'd1;

  // NOTE: every output of always_comb gets a default first so no latch is inferred.
  always_comb begin
    hex_ok  = 1'b1;
    hex_val = 4'd0;
    case (cand)
      7'h3F: hex_val = 4'h0;
      7'h06: hex_val = 4'h1;
      7'h5B: hex_val = 4'h2;
      7'h4F: hex_val = 4'h3;
      7'h66: hex_val = 4'h4;
      7'h6D: hex_val = 4'h5;
      7'h7D: hex_val = 4'h6;
      7'h07: hex_val = 4'h7;
      7'h7F: hex_val = 4'h8;
      7'h6F: hex_val = 4'h9;
      7'h77: hex_val = 4'hA;
      7'h7C: hex_val = 4'hB;
      7'h39: hex_val = 4'hC;
      7'h5E: hex_val = 4'hD;
      7'h79: hex_val = 4'hE;
      7'h71: hex_val = 4'hF;
      default: hex_ok = 1'b0;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only; reset is sampled on the clock edge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1    <= '0;
      s        <= '0;
      cand     <= '0;
      cnt      <= '0;
      last_acc <= '0;
      digit    <= '0;
      valid    <= 1'b0;
      bad_pat  <= 1'b0;
      seq_err  <= 1'b0;
      strobe   <= 1'b0;
      count    <= '0;
      state    <= ST_WAIT_FIRST;
    end else begin
      sync1  <= ui_in;
      s      <= sync1;
      strobe <= 1'b0;

      if (p != cand) begin
        cand <= p;
        cnt  <= '0;
      end else if (cnt < CNT_MAX) begin
        cnt <= cnt + 8'd1;
      end

      // Clear leaves the filter alone so a pattern held through it is not re-accepted.
      if (c) begin
        digit   <= '0;
        valid   <= 1'b0;
        bad_pat <= 1'b0;
        seq_err <= 1'b0;
        count   <= '0;
        state   <= ST_WAIT_FIRST;
      end else if (accept_rdy) begin
        last_acc <= cand;
        if (hex_ok) begin
          digit  <= hex_val;
          valid  <= 1'b1;
          strobe <= 1'b1;
          count  <= count + 8'd1;
          if (state == ST_TRACK && hex_val != exp_next) seq_err <= 1'b1;
          state  <= ST_TRACK;
        end else if (cand != 7'h00) begin
          bad_pat <= 1'b1;
        end
      end
    end
  end

  assign uo_out  = {strobe, seq_err, bad_pat, valid, digit};
  assign uio_out = count;
  assign uio_oe  = 8'hFF;

  logic unused;
  assign unused = &{1'b0, uio_in, ena};

endmodule

// File: tb/tb_tt_um_seven_segment_sniffer.sv
// Scoreboard bench for the seven-segment sniffer: stimulus queues the expected strobe
// responses, a negedge monitor pops and compares them, and directed state checks sit between.
module tb_tt_um_seven_segment_sniffer;

  localparam int SC = 4;

  typedef struct {
    logic [7:0] uo;
    logic [7:0] uio;
    int         cyc;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] ui_in;
  logic [7:0] uo_out, uio_out, uio_oe;
  logic [7:0] uio_in = 8'h00;
  logic       ena = 1'b1;

  int   n_vec = 0;
  int   n_err = 0;
  int   cyc   = 0;
  exp_t sb[$];
  exp_t e;
  logic [6:0] seg [10];

  tt_um_seven_segment_sniffer #(.STABLE_CYCLES(SC), .WRAP(4'd9)) dut (
    .ui_in  (ui_in),
    .uo_out (uo_out),
    .uio_in (uio_in),
    .uio_out(uio_out),
    .uio_oe (uio_oe),
    .ena    (ena),
    .clk    (clk),
    .rst_n  (rst_n)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0h, wanted %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Holds {clr, pat} for n clock edges; queues one strobe response when expected.
  task automatic drive(input logic [6:0] pat, input logic clr, input int n,
                       input logic exp_strobe, input logic [7:0] exp_uo, input logic [7:0] exp_uio);
    exp_t x;
    @(negedge clk);
    ui_in = {clr, pat};
    if (exp_strobe) begin
      x.uo  = exp_uo;
      x.uio = exp_uio;
      x.cyc = cyc + SC + 3;
      sb.push_back(x);
    end
    repeat (n - 1) @(negedge clk);
  endtask

  task automatic check_state(input string name, input logic [7:0] exp_uo, input logic [7:0] exp_uio);
    @(negedge clk);
    check({name, "_uo"}, 32'(uo_out), 32'(exp_uo));
    check({name, "_uio"}, 32'(uio_out), 32'(exp_uio));
  endtask

  always @(negedge clk) begin
    if (rst_n === 1'b1 && uo_out[7] === 1'b1) begin
      if (sb.size() == 0) begin
        check("spurious_strobe", 32'(uo_out), 32'h0);
      end else begin
        e = sb.pop_front();
        check("strobe_uo", 32'(uo_out), 32'(e.uo));
        check("strobe_uio", 32'(uio_out), 32'(e.uio));
        check("strobe_cycle", 32'(cyc), 32'(e.cyc));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, wanted completion");
    $fatal(1, "watchdog");
  end

  initial begin
    seg[0] = 7'h3F; seg[1] = 7'h06; seg[2] = 7'h5B; seg[3] = 7'h4F; seg[4] = 7'h66;
    seg[5] = 7'h6D; seg[6] = 7'h7D; seg[7] = 7'h07; seg[8] = 7'h7F; seg[9] = 7'h6F;
    rst_n = 1'b0;
    ui_in = 8'h00;
    repeat (3) @(negedge clk);
    check("reset_uo", 32'(uo_out), 32'h00);
    check("reset_uio", 32'(uio_out), 32'h00);
    check("reset_oe", 32'(uio_oe), 32'hFF);
    rst_n = 1'b1;

    // First digit after reset, then 1..9 and wrap to 0 with no sequence error.
    drive(7'h3F, 1'b0, 12, 1'b1, 8'h90, 8'd1);
    check_state("after_first", 8'h10, 8'd1);
    for (int i = 1; i <= 10; i++)
      drive(seg[i % 10], 1'b0, 8, 1'b1, 8'h90 | 8'(i % 10), 8'(i + 1));
    check_state("after_count", 8'h10, 8'd11);

    // Short glitch of 1 ignored, then 2 after 0 flags a sequence error.
    drive(7'h06, 1'b0, 3, 1'b0, 8'h00, 8'h00);
    drive(7'h5B, 1'b0, 8, 1'b1, 8'hD2, 8'd12);
    check_state("after_skip", 8'h52, 8'd12);

    // Clear with 2 held, then 3 becomes the first digit; an invalid pattern sets bad_pat.
    drive(7'h5B, 1'b1, 3, 1'b0, 8'h00, 8'h00);
    drive(7'h5B, 1'b0, 4, 1'b0, 8'h00, 8'h00);
    check_state("after_clear1", 8'h00, 8'h00);
    drive(7'h4F, 1'b0, 8, 1'b1, 8'h93, 8'd1);
    drive(7'h55, 1'b0, 10, 1'b0, 8'h00, 8'h00);
    check_state("bad_pattern", 8'h33, 8'd1);
    drive(7'h66, 1'b0, 8, 1'b1, 8'hB4, 8'd2);

    // Blank between two 1s lets the second be accepted, which breaks the sequence.
    drive(7'h66, 1'b1, 3, 1'b0, 8'h00, 8'h00);
    drive(7'h66, 1'b0, 4, 1'b0, 8'h00, 8'h00);
    check_state("after_clear2", 8'h00, 8'h00);
    drive(7'h3F, 1'b0, 8, 1'b1, 8'h90, 8'd1);
    drive(7'h06, 1'b0, 8, 1'b1, 8'h91, 8'd2);
    drive(7'h00, 1'b0, 8, 1'b0, 8'h00, 8'h00);
    drive(7'h06, 1'b0, 8, 1'b1, 8'hD1, 8'd3);
    check_state("blank_repeat", 8'h51, 8'd3);
    drive(7'h55, 1'b0, 8, 1'b0, 8'h00, 8'h00);
    check_state("both_flags", 8'h71, 8'd3);
    drive(7'h06, 1'b0, 8, 1'b1, 8'hF1, 8'd4);

    // Two-cycle clear pulse with 1 held: effective after the synchronizer, no re-accept.
    @(negedge clk);
    ui_in = {1'b1, 7'h06};
    @(negedge clk);
    @(negedge clk);
    check("clear_not_yet", 32'(uo_out), 32'h71);
    ui_in = {1'b0, 7'h06};
    @(negedge clk);
    check("clear_uo", 32'(uo_out), 32'h00);
    check("clear_uio", 32'(uio_out), 32'h00);
    repeat (10) @(negedge clk);
    check_state("clear_held", 8'h00, 8'h00);
    drive(7'h5B, 1'b0, 8, 1'b1, 8'h92, 8'd1);

    // 257 accepts in sequence: count wraps 255 -> 0 with no flag.
    drive(7'h5B, 1'b1, 3, 1'b0, 8'h00, 8'h00);
    drive(7'h5B, 1'b0, 4, 1'b0, 8'h00, 8'h00);
    for (int i = 0; i <= 256; i++)
      drive(seg[i % 10], 1'b0, 6, 1'b1, 8'h90 | 8'(i % 10), 8'((i + 1) % 256));
    repeat (10) @(negedge clk);
    check("final_uo", 32'(uo_out), 32'h16);
    check("final_uio", 32'(uio_out), 32'h01);
    check("queue_drained", 32'(sb.size()), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
